ham_decoder: RTL and testbench

Registered Hamming(7,4) single-error-correcting decoder.
- Accepts a 7-bit codeword, computes the 3-bit syndrome, flips the indicated bit, and outputs the 4 corrected data bits with status flags.
- Sits on the receive side of the channel-coding datapath, downstream of the link/RX capture stage.
- One-cycle registered latency; no backpressure.

---
 rtl/ham_decoder.sv | 146 ++++++++++++++
 tb/tb_ham_decoder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ham_decoder.sv
// ---------------------------------------------------------------------------
// ham_decoder -- registered Hamming(7,4) single-error-correcting decoder.
//
// Takes a 7-bit received codeword, computes the 3-bit syndrome, optionally
// flips the indicated position, and registers the 4 data bits plus status
// flags. One cycle of latency, one word per cycle, no backpressure.
//
// Codeword position map (e[k-1] = position k):
//   pos1=p1 pos2=p2 pos3=d1 pos4=p3 pos5=d2 pos6=d3 pos7=d4 (even parity)
//
// Parameters:
//   CORRECT    1 = flip the bit named by a nonzero syndrome,
//              0 = detect only (data passed through, flags still valid)
//
// Optional build macro:
//   HAM_DEC_SECDED_EN  adds an overall parity input (e_par) and a
//                      double-error flag (dbl_err) for SECDED operation.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   in_valid   in   e is valid this cycle
//   e[6:0]     in   received codeword
//   e_par      in   overall even parity over e      (SECDED build only)
//   out_valid  out  one-cycle pulse per accepted word
//   p[3:0]     out  corrected data {d4,d3,d2,d1}
//   syndrome   out  {s4,s2,s1}; value = erroneous position, 0 = clean
//   err        out  single error detected/corrected
//   dbl_err    out  double error detected           (SECDED build only)
// ---------------------------------------------------------------------------
module ham_decoder #(
  parameter bit CORRECT = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [6:0] e,
`ifdef HAM_DEC_SECDED_EN
  input  logic       e_par,
  output logic       dbl_err,
`endif
  output logic       out_valid,
  output logic [3:0] p,
  output logic [2:0] syndrome,
  output logic       err
);

  // Syndrome {s4,s2,s1}: each bit is the even-parity check over the
  // positions whose index has that bit set.
  function automatic logic [2:0] calc_syndrome(input logic [6:0] cw);
    logic s1;
    logic s2;
    logic s4;
    s1 = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
    s2 = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
    s4 = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
    return {s4, s2, s1};
  endfunction

  // One-hot flip mask for the position named by the syndrome.
  function automatic logic [6:0] flip_mask(input logic [2:0] s);
    logic [6:0] m;
    case (s)
      3'd1:    m = 7'b000_0001;
      3'd2:    m = 7'b000_0010;
      3'd3:    m = 7'b000_0100;
      3'd4:    m = 7'b000_1000;
      3'd5:    m = 7'b001_0000;
      3'd6:    m = 7'b010_0000;
      3'd7:    m = 7'b100_0000;
      default: m = 7'b000_0000;
    endcase
    return m;
  endfunction

  // Data bits live at positions 7,6,5,3.
  function automatic logic [3:0] extract_data(input logic [6:0] cw);
    return {cw[6], cw[5], cw[4], cw[2]};
  endfunction

  logic [2:0] syn_s;
  logic [6:0] fixed_s;
  logic       err_s;
`ifdef HAM_DEC_SECDED_EN
  logic       dbl_s;
  logic       q_s;
`endif

  // Decode: syndrome, error classification and (optional) correction.
  always_comb begin
    syn_s   = calc_syndrome(e);
    fixed_s = e;
    err_s   = 1'b0;
`ifdef HAM_DEC_SECDED_EN
    dbl_s   = 1'b0;
    q_s     = (^e) ^ e_par;
    if (q_s) begin
      // Odd overall parity: a single error, either in e or in e_par alone.
      // A zero syndrome yields an all-zero mask, so data stays unchanged.
      err_s = 1'b1;
      if (CORRECT) begin
        fixed_s = e ^ flip_mask(syn_s);
      end else begin
        fixed_s = e;
      end
    end else if (syn_s != 3'd0) begin
      // Even overall parity but nonzero syndrome: two bits flipped, so the
      // syndrome does not point at a real error and nothing is corrected.
      dbl_s = 1'b1;
    end else begin
      dbl_s = 1'b0;
    end
`else
    err_s = (syn_s != 3'd0);
    if (CORRECT) begin
      fixed_s = e ^ flip_mask(syn_s);
    end else begin
      fixed_s = e;
    end
`endif
  end

  // Output registers: load on an accepted word, otherwise hold data/flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      p         <= 4'd0;
      syndrome  <= 3'd0;
      err       <= 1'b0;
`ifdef HAM_DEC_SECDED_EN
      dbl_err   <= 1'b0;
`endif
    end else if (in_valid) begin
      out_valid <= 1'b1;
      p         <= extract_data(fixed_s);
      syndrome  <= syn_s;
      err       <= err_s;
`ifdef HAM_DEC_SECDED_EN
      dbl_err   <= dbl_s;
`endif
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ham_decoder.sv
// ---------------------------------------------------------------------------
// tb_ham_decoder -- directed self-checking bench for ham_decoder.
// Two instances: u_dut (CORRECT=1) and u_nc (CORRECT=0, detect only).
// All test words derive from the clean codeword 7'b1100110 (data 4'b1101,
// overall parity 0), so e_par is held at 0 except where a parity-bit error
// is being injected.
// ---------------------------------------------------------------------------
module tb_ham_decoder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [6:0] e;
  logic       e_par;

  logic       out_valid;
  logic [3:0] p;
  logic [2:0] syndrome;
  logic       err;
  logic       out_valid_nc;
  logic [3:0] p_nc;
  logic [2:0] syndrome_nc;
  logic       err_nc;
`ifdef HAM_DEC_SECDED_EN
  logic       dbl_err;
  logic       dbl_err_nc;
`endif

  int total_cnt = 0;
  int pass_cnt  = 0;

  ham_decoder #(.CORRECT(1'b1)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .e        (e),
`ifdef HAM_DEC_SECDED_EN
    .e_par    (e_par),
    .dbl_err  (dbl_err),
`endif
    .out_valid(out_valid),
    .p        (p),
    .syndrome (syndrome),
    .err      (err)
  );

  ham_decoder #(.CORRECT(1'b0)) u_nc (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .e        (e),
`ifdef HAM_DEC_SECDED_EN
    .e_par    (e_par),
    .dbl_err  (dbl_err_nc),
`endif
    .out_valid(out_valid_nc),
    .p        (p_nc),
    .syndrome (syndrome_nc),
    .err      (err_nc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Check the full CORRECT=1 output set.
  task automatic check_all(input string tag, input logic ov, input logic [3:0] ep,
                           input logic [2:0] es, input logic ee);
    check({tag, ".out_valid"}, {7'd0, out_valid}, {7'd0, ov});
    check({tag, ".p"},         {4'd0, p},         {4'd0, ep});
    check({tag, ".syndrome"},  {5'd0, syndrome},  {5'd0, es});
    check({tag, ".err"},       {7'd0, err},       {7'd0, ee});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b1;
    e        = 7'b1110110;
    e_par    = 1'b0;

    // Reset held two cycles with a valid word present: reset dominates.
    step();
    step();
    check_all("reset", 1'b0, 4'd0, 3'd0, 1'b0);
    check("reset_nc.p", {4'd0, p_nc}, 8'd0);
`ifdef HAM_DEC_SECDED_EN
    check("reset.dbl_err", {7'd0, dbl_err}, 8'd0);
`endif

    // Clean word.
    rst_n = 1'b1;
    in_valid = 1'b1; e = 7'b1100110;
    step();
    check_all("clean", 1'b1, 4'b1101, 3'b000, 1'b0);
    in_valid = 1'b0;
    step();
    check("clean_pulse.out_valid", {7'd0, out_valid}, 8'd0);
    check("clean_hold.p", {4'd0, p}, {4'd0, 4'b1101});

    // Streaming: pos5 data error, pos1 parity error, pos7 MSB error.
    in_valid = 1'b1; e = 7'b1110110;
    step();
    check_all("pos5", 1'b1, 4'b1101, 3'b101, 1'b1);
    check("pos5_nc.p", {4'd0, p_nc}, {4'd0, 4'b1111});
    e = 7'b1100111;
    step();
    check_all("pos1", 1'b1, 4'b1101, 3'b001, 1'b1);
    check("pos1_nc.p", {4'd0, p_nc}, {4'd0, 4'b1101});
    e = 7'b0100110;
    step();
    check_all("pos7", 1'b1, 4'b1101, 3'b111, 1'b1);
    check("pos7_nc.p", {4'd0, p_nc}, {4'd0, 4'b0101});
    check("pos7_nc.err", {7'd0, err_nc}, 8'd1);
    check("pos7_nc.syndrome", {5'd0, syndrome_nc}, {5'd0, 3'b111});

    // Idle: outputs hold the last word, no pulse; e changes are ignored.
    in_valid = 1'b0; e = 7'b0000000;
    step();
    check_all("hold1", 1'b0, 4'b1101, 3'b111, 1'b1);
    step();
    check_all("hold2", 1'b0, 4'b1101, 3'b111, 1'b1);
    check("hold2_nc.p", {4'd0, p_nc}, {4'd0, 4'b0101});

    // pos3 data error (d1).
    in_valid = 1'b1; e = 7'b1100010;
    step();
    check_all("pos3", 1'b1, 4'b1101, 3'b011, 1'b1);
    check("pos3_nc.p", {4'd0, p_nc}, {4'd0, 4'b1100});

    // Reset mid-stream: the word in the reset cycle is discarded.
    rst_n = 1'b0; e = 7'b1110110;
    step();
    check_all("midrst", 1'b0, 4'd0, 3'd0, 1'b0);
    rst_n = 1'b1; in_valid = 1'b0;
    step();
    check_all("midrst_after", 1'b0, 4'd0, 3'd0, 1'b0);

    // A different clean codeword: data 4'b0000 -> all-zero word.
    in_valid = 1'b1; e = 7'b0000000;
    step();
    check_all("zero", 1'b1, 4'b0000, 3'b000, 1'b0);

`ifdef HAM_DEC_SECDED_EN
    // Double error (pos1+pos5): flagged, not corrected.
    e = 7'b1110111; e_par = 1'b0;
    step();
    check("dbl.syndrome", {5'd0, syndrome}, {5'd0, 3'b100});
    check("dbl.dbl_err", {7'd0, dbl_err}, 8'd1);
    check("dbl.err", {7'd0, err}, 8'd0);
    check("dbl.p", {4'd0, p}, {4'd0, 4'b1111});
    // Error in e_par only.
    e = 7'b1100110; e_par = 1'b1;
    step();
    check("epar.err", {7'd0, err}, 8'd1);
    check("epar.syndrome", {5'd0, syndrome}, 8'd0);
    check("epar.p", {4'd0, p}, {4'd0, 4'b1101});
    check("epar.dbl_err", {7'd0, dbl_err}, 8'd0);
    e_par = 1'b0;
`endif

    in_valid = 1'b0;
    step();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
